// File: rtl/cvt_itof_pipe_if.sv
// rtl/cvt_itof_pipe_if.sv - handshake/data bundle for the integer-to-float converter
//
// Purpose: groups the input sample and output result signals of cvt_itof_pipe.
// Signals:
//    in_valid  - src is sampled this cycle
//    src       - 32-bit integer operand
//    out_valid - res holds a new result this cycle (single-cycle pulse)
//    res       - IEEE-754 single-precision result, held while out_valid=0
// Modports:
//    master - producer side (drives in_valid/src, observes out_valid/res)
//    slave  - converter side
interface cvt_itof_pipe_if;
   logic        in_valid;
   logic [31:0] src;
   logic        out_valid;
   logic [31:0] res;

   modport master (
      output in_valid,
      output src,
      input  out_valid,
      input  res
   );

   modport slave (
      input  in_valid,
      input  src,
      output out_valid,
      output res
   );
endinterface

// File: rtl/cvt_itof_pipe.sv
// rtl/cvt_itof_pipe.sv - pipelined 32-bit integer to IEEE-754 single converter
//
// Purpose: converts a 32-bit integer (signed or unsigned, chosen by SIGNED_IN)
// to single precision with round-to-nearest-even. Three register stages:
// sign/magnitude, normalize, round/pack. One input per cycle, no backpressure.
// Ports:
//    clk - system clock, rising edge
//    rst - synchronous active-high reset; clears every stage valid and res
//    bus - cvt_itof_pipe_if.slave: in_valid/src in, out_valid/res out
// Parameters:
//    SIGNED_IN - 1: src is two's complement, 0: src is unsigned
module cvt_itof_pipe #(
   parameter bit SIGNED_IN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   cvt_itof_pipe_if.slave  bus
);

   // ---------------- stage 1: sign / magnitude ----------------
   logic        s1_valid;
   logic        s1_sign;
   logic [32:0] s1_mag;

   logic        neg_in;
   logic [32:0] mag_in;

   always_comb begin
      neg_in = SIGNED_IN && bus.src[31];
      // 33-bit negate so that -2^31 yields +2^31 without wrapping
      if (neg_in)
         mag_in = {1'b0, ~bus.src} + 33'd1;
      else
         mag_in = {1'b0, bus.src};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= bus.in_valid;
         s1_sign  <= neg_in;
         s1_mag   <= mag_in;
      end
   end

   // ---------------- stage 2: normalize ----------------
   logic        s2_valid;
   logic        s2_sign;
   logic        s2_zero;
   logic [4:0]  s2_lz;
   // bit 31 of the normalized value is the implicit leading one (or zero for
   // a zero input, which is handled by s2_zero), so only bits 30:0 are kept
   logic [30:0] s2_norm;

   logic [4:0]  lz;
   logic        lz_found;
   logic [31:0] norm;

   always_comb begin
      lz       = 5'd0;
      lz_found = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         if (!lz_found && s1_mag[i]) begin
            lz       = 5'(31 - i);
            lz_found = 1'b1;
         end
      end
      norm = s1_mag[31:0] << lz;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_zero  <= (s1_mag == 33'd0);
         s2_lz    <= lz;
         s2_norm  <= norm[30:0];
      end
   end

   // ---------------- stage 3: round and pack ----------------
   logic        out_valid_q;
   logic [31:0] res_q;

   logic [22:0] mant;
   logic        guard;
   logic        sticky;
   logic        round_up;
   logic [23:0] mant_sum;
   logic        carry;
   logic [22:0] mant_out;
   logic [7:0]  exp_out;
   logic [31:0] packed_res;

   always_comb begin
      mant     = s2_norm[30:8];
      guard    = s2_norm[7];
      sticky   = |s2_norm[6:0];
      round_up = guard & (sticky | mant[0]);
      mant_sum = {1'b0, mant} + {23'd0, round_up};
      carry    = mant_sum[23];
      // a carry out of the mantissa means it wrapped to 1.0 * 2^(e+1)
      mant_out = carry ? 23'd0 : mant_sum[22:0];
      // 127 bias + 31 for an MSB at bit 31; max is 159, never overflows
      exp_out  = 8'd158 - {3'd0, s2_lz} + {7'd0, carry};
      if (s2_zero)
         packed_res = 32'h0000_0000;
      else
         packed_res = {s2_sign, exp_out, mant_out};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         res_q       <= 32'h0000_0000;
      end else begin
         out_valid_q <= s2_valid;
         if (s2_valid)
            res_q <= packed_res;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.res       = res_q;

endmodule
